sample_fifo_ctrl: RTL and testbench

FIFO controller that owns the single-port synchronous sample RAM (24-bit words, 512 deep, one-cycle registered read, old-data read-during-write) and turns it into a streaming audio sample buffer. Upstream producers push samples through a valid/ready port. The block schedules one RAM access per cycle, either a write or a read, and absorbs the RAM's one-cycle read latency into an output register. Downstream consumers pop samples through a second valid/ready port.

---
 rtl/sample_fifo_if.sv | 22 ++
 rtl/sample_fifo_ctrl.sv | 100 ++++++++++
 tb/tb_sample_fifo_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_fifo_if.sv
// Producer/consumer streaming port of the sample FIFO controller.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1; ready never depends on valid.
interface sample_fifo_if #(
  parameter int WORD_SIZE = 24
);
  logic                 in_valid;
  logic [WORD_SIZE-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [WORD_SIZE-1:0] out_data;
  logic                 out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sample_fifo_ctrl.sv
// Streaming sample buffer on top of a single-port synchronous RAM: one RAM access per cycle,
// read has priority, and the one-cycle read latency is absorbed into an output register.
module sample_fifo_ctrl #(
  parameter int WORD_SIZE = 24,
  parameter int N_WORDS   = 512,
  localparam int AW       = $clog2(N_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  sample_fifo_if.slave         s,
  output logic [AW:0]          level,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_a,
  output logic [WORD_SIZE-1:0] mem_din,
  input  logic [WORD_SIZE-1:0] mem_dout
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_WORDS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(N_WORDS);

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          ram_cnt_q, ram_cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0] out_data_q, out_data_d;

  logic rd_issue;
  logic rd_en;
  logic wr_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  // A read is only issued into an empty output stage, so capture never meets a pop.
  assign rd_issue   = (ram_cnt_q != '0) && !rd_pend_q && !out_valid_q;
  assign rd_en      = rd_issue && !flush;
  assign s.in_ready = !rd_issue && (ram_cnt_q != FULL_CNT) && !flush;
  assign wr_en      = s.in_valid && s.in_ready;

  assign mem_we  = wr_en;
  assign mem_a   = wr_en ? wr_ptr_q : rd_ptr_q;
  assign mem_din = wr_en ? s.in_data : '0;

  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign level       = ram_cnt_q + {{AW{1'b0}}, rd_pend_q} + {{AW{1'b0}}, out_valid_q};

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    rd_pend_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_cnt_d   = '0;
      out_valid_d = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d  = ptr_inc(wr_ptr_q);
        ram_cnt_d = ram_cnt_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d  = ptr_inc(rd_ptr_q);
        ram_cnt_d = ram_cnt_q - 1'b1;
        rd_pend_d = 1'b1;
      end
      if (rd_pend_q) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_dout;
      end else if (out_valid_q && s.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_sample_fifo_ctrl.sv
// Bench for sample_fifo_ctrl with a 4-deep behavioural RAM; every accepted sample is queued
// and compared in order when it leaves the output port.
module tb_sample_fifo_ctrl;
  localparam int WS = 24;
  localparam int NW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [AW:0]   level;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [WS-1:0] mem_din;
  logic [WS-1:0] mem_dout;

  sample_fifo_if #(.WORD_SIZE(WS)) bus ();

  sample_fifo_ctrl #(.WORD_SIZE(WS), .N_WORDS(NW)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .s        (bus),
    .level    (level),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // clock / reset
  always #5 clk = ~clk;

  // single-port RAM, registered read, old data on read-during-write
  logic [WS-1:0] ram [0:NW-1];
  logic [WS-1:0] ram_rd_q;
  always @(posedge clk) begin
    if (mem_we) ram[mem_a] <= mem_din;
    ram_rd_q <= ram[mem_a];
  end
  assign mem_dout = ram_rd_q;

  // scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [WS-1:0] exp_q[$];
  logic [AW-1:0] exp_wa = '0;
  bit            thr_mode = 0;

  logic          s_in_ready, s_out_valid, s_we, accepted;
  logic [WS-1:0] s_out_data;
  logic [AW-1:0] s_mem_a;
  logic [AW:0]   s_level;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // drivers
  task drive(input logic v, input logic [WS-1:0] d, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  // One clock cycle: called at the falling edge, samples just after it, returns at the next falling edge.
  task step;
    #1;
    s_in_ready  = bus.in_ready;
    s_out_valid = bus.out_valid;
    s_out_data  = bus.out_data;
    s_we        = mem_we;
    s_mem_a     = mem_a;
    s_level     = level;
    accepted    = bus.in_valid && s_in_ready;
    if (flush) begin
      check("flush_we", s_we, 0);
      check("flush_rdy", s_in_ready, 0);
    end else begin
      if (accepted) begin
        check("wr_we", s_we, 1);
        check("wr_addr", s_mem_a, exp_wa);
        check("wr_din", mem_din, bus.in_data);
        exp_q.push_back(bus.in_data);
        exp_wa = (exp_wa == AW'(NW - 1)) ? '0 : exp_wa + 1'b1;
      end else begin
        check("idle_we", s_we, 0);
      end
      if (thr_mode) check("thr_ready", s_in_ready, s_we);
      if (s_out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("sb_qsize", exp_q.size(), 1);
        else check("sb_data", s_out_data, exp_q.pop_front());
      end
    end
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
      exp_wa = '0;
    end
    @(negedge clk);
  endtask

  task drain(input int maxc);
    drive(0, '0, 1, 0);
    for (int c = 0; c < maxc; c++) begin
      if (exp_q.size() == 0 && level == '0) break;
      step;
    end
    check("drain_q", exp_q.size(), 0);
    check("drain_lvl", level, 0);
  endtask

  task push_n(input int n_req, input logic ordy, input logic [WS-1:0] base, output int n_got);
    n_got = 0;
    for (int c = 0; c < 40 && n_got < n_req; c++) begin
      drive(1, base + WS'(n_got), ordy, 0);
      step;
      if (accepted) n_got++;
    end
    drive(0, '0, ordy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int            n;
  int            k;
  bit            held_ok;
  logic [WS-1:0] held;

  initial begin
    drive(0, '0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ov", bus.out_valid, 0);
    check("rst_od", bus.out_data, 0);
    check("rst_lvl", level, 0);
    @(negedge clk);
    reset = 1'b0;
    step;
    check("rst_rdy", s_in_ready, 1);

    // single-sample latency
    drive(1, 24'hABCDEF, 1, 0);
    step;
    check("lat_we0", s_we, 1);
    check("lat_a0", s_mem_a, 0);
    drive(0, '0, 1, 0);
    step;
    check("lat_we1", s_we, 0);
    check("lat_a1", s_mem_a, 0);
    check("lat_rdy1", s_in_ready, 0);
    check("lat_lvl1", s_level, 1);
    step;
    check("lat_ov2", s_out_valid, 0);
    check("lat_lvl2", s_level, 1);
    step;
    check("lat_ov3", s_out_valid, 1);
    check("lat_od3", s_out_data, 24'hABCDEF);
    check("lat_lvl3", s_level, 1);
    step;
    check("lat_ov4", s_out_valid, 0);
    check("lat_lvl4", s_level, 0);

    // ordered streaming with in_valid held
    thr_mode = 1;
    k = 1;
    for (int c = 0; c < 80 && k <= 16; c++) begin
      drive(1, WS'(k), 1, 0);
      step;
      if (accepted) k++;
    end
    thr_mode = 0;
    check("thr_count", k, 17);
    drain(40);

    // fill to the boundary under backpressure
    n = 0;
    held_ok = 0;
    held = '0;
    for (int c = 0; c < 20; c++) begin
      drive(1, WS'($urandom_range(0, 24'hFFFFFF)), 0, 0);
      step;
      if (accepted) n++;
      if (s_out_valid) begin
        if (held_ok) check("bp_hold", s_out_data, held);
        else begin
          held = s_out_data;
          held_ok = 1;
        end
      end
    end
    check("full_n", n, 5);
    check("full_lvl", level, 5);
    check("full_rdy", bus.in_ready, 0);
    check("full_ov", bus.out_valid, 1);
    drain(40);

    // pointer wrap
    push_n(6, 1, 24'h000300, n);
    check("wrap_n", n, 6);
    drain(40);

    // flush with a read in flight
    push_n(4, 0, 24'h000400, n);
    check("fl_n", n, 4);
    check("fl_lvl4", level, 4);
    drive(0, '0, 1, 0);
    step;
    drive(0, '0, 0, 0);
    step;
    check("fl_lvl_pre", level, 3);
    drive(1, 24'h0004AA, 1, 1);
    step;
    check("fl_lvl_post", level, 0);
    check("fl_ov_post", bus.out_valid, 0);
    drive(1, 24'h0004BB, 1, 0);
    step;
    check("fl_addr", s_mem_a, 0);
    drain(40);

    // asynchronous reset mid-stream
    push_n(3, 0, 24'h000500, n);
    check("rm_n", n, 3);
    #2;
    reset = 1'b1;
    #1;
    check("rm_ov", bus.out_valid, 0);
    check("rm_lvl", level, 0);
    exp_q.delete();
    exp_wa = '0;
    @(negedge clk);
    reset = 1'b0;
    drive(1, 24'h5A5A5A, 1, 0);
    step;
    check("rm_rdy", s_in_ready, 1);
    check("rm_a", s_mem_a, 0);
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
